// File: rtl/proc_run_ctrl.sv
// rtl/proc_run_ctrl.sv - processor run controller: hold reset, run N cycles, capture and compare result
// Optional saturating pass counter enabled by defining RUN_CTRL_PASSCNT_EN.
module proc_run_ctrl #(
    parameter int HOLD_CYCLES = 1,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             Reset_L,
    input  logic             start,
    input  logic [31:0]      start_pc_in,
    input  logic [CNT_W-1:0] run_cycles,
    input  logic [31:0]      expected,
    input  logic [31:0]      dmem_out,
    output logic             proc_reset_l,
    output logic [31:0]      proc_start_pc,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [31:0]      result,
    output logic [7:0]       pass_count
);

    typedef enum logic [1:0] {IDLE, HOLD, RUN, CHECK} state_t;

    state_t           state;
    logic [7:0]       hold_cnt;
    logic [CNT_W-1:0] run_cnt;
    logic [31:0]      exp_lat;
    logic             match;

    assign match = (dmem_out == exp_lat);

`ifndef RUN_CTRL_PASSCNT_EN
    assign pass_count = 8'd0;
`endif

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state         <= IDLE;
            hold_cnt      <= 8'd0;
            run_cnt       <= '0;
            exp_lat       <= 32'd0;
            proc_reset_l  <= 1'b0;
            proc_start_pc <= 32'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            result        <= 32'd0;
`ifdef RUN_CTRL_PASSCNT_EN
            pass_count    <= 8'd0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // Processor keeps free-running the last program while idle
                    proc_reset_l <= 1'b1;
                    if (start) begin
                        state         <= HOLD;
                        busy          <= 1'b1;
                        proc_reset_l  <= 1'b0;
                        proc_start_pc <= start_pc_in;
                        run_cnt       <= run_cycles;
                        exp_lat       <= expected;
                        hold_cnt      <= 8'(HOLD_CYCLES);
                    end
                end
                HOLD: begin
                    if (hold_cnt == 8'd1) begin
                        proc_reset_l <= 1'b1;
                        state        <= (run_cnt == '0) ? CHECK : RUN;
                    end else begin
                        hold_cnt <= hold_cnt - 8'd1;
                    end
                end
                RUN: begin
                    if (run_cnt == CNT_W'(1)) begin
                        state <= CHECK;
                    end else begin
                        run_cnt <= run_cnt - CNT_W'(1);
                    end
                end
                CHECK: begin
                    result <= dmem_out;
                    pass   <= match;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
`ifdef RUN_CTRL_PASSCNT_EN
                    if (match && pass_count != 8'hFF) begin
                        pass_count <= pass_count + 8'd1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
